line_burst_ctrl: RTL

- Converts single-cycle cache-line requests into 64-bit multi-beat burst commands for the burst RAM port.
- Supports line read and line write; drives cmd/cmd_en/addr/wr_data and collects rd_data beats into one line.
- Sits directly upstream of the burst RAM, between the cache and the RAM.

---
 rtl/line_burst_ctrl_pkg.sv | 15 +
 rtl/line_burst_ctrl_beat_buffer.sv | 42 ++++
 rtl/line_burst_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/line_burst_ctrl_pkg.sv
// Shared FSM encoding and RAM command constants for line_burst_ctrl.
package line_burst_ctrl_pkg;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WR_ISSUE   = 3'd1;
    localparam logic [2:0] WR_BEATS   = 3'd2;
    localparam logic [2:0] RD_ISSUE   = 3'd3;
    localparam logic [2:0] RD_COLLECT = 3'd4;
    localparam logic [2:0] WAIT_IDLE  = 3'd5;
    localparam logic [2:0] RESP       = 3'd6;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/line_burst_ctrl_beat_buffer.sv
// line_beat_buffer: BURST_COUNT x DATA_BITWIDTH slot register, used to serialize
// write lines and to assemble read lines.
module line_beat_buffer #(
    parameter int BURST_COUNT   = 4,
    parameter int DATA_BITWIDTH = 64,
    localparam int IW           = $clog2(BURST_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load_en,
    input  logic [BURST_COUNT*DATA_BITWIDTH-1:0] load_line,
    input  logic                                 wr_en,
    input  logic [IW-1:0]                        wr_idx,
    input  logic [DATA_BITWIDTH-1:0]             wr_data,
    input  logic [IW-1:0]                        rd_idx,
    output logic [DATA_BITWIDTH-1:0]             rd_data,
    output logic [BURST_COUNT*DATA_BITWIDTH-1:0] line_nxt
);

    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] slots;
    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] slots_nxt;

    always_comb begin
        slots_nxt = slots;
        if (load_en)
            slots_nxt = load_line;
        else if (wr_en)
            slots_nxt[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            slots <= '0;
        else
            slots <= slots_nxt;
    end

    assign rd_data  = slots[rd_idx];
    // Exposes the line including this cycle's write so the last beat lands in resp_rdata.
    assign line_nxt = slots_nxt;

endmodule

// File: rtl/line_burst_ctrl.sv
// Cache-line to burst-RAM command controller. Optional read watchdog is built
// when LINE_BURST_CTRL_TIMEOUT_EN is defined.
module line_burst_ctrl
    import line_burst_ctrl_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int LINE_BITWIDTH  = DATA_BITWIDTH * BURST_COUNT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              req_valid,
    output logic                                              req_ready,
    input  logic                                              req_write,
    input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0]     req_addr,
    input  logic [LINE_BITWIDTH-1:0]                          req_wdata,
    output logic                                              resp_valid,
    output logic [LINE_BITWIDTH-1:0]                          resp_rdata,
    output logic                                              resp_err,
    output logic                                              ram_cmd,
    output logic                                              ram_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]                         ram_addr,
    output logic [DATA_BITWIDTH-1:0]                          ram_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]                        ram_data_mask,
    input  logic [DATA_BITWIDTH-1:0]                          ram_rd_data,
    input  logic                                              ram_rd_data_valid,
    input  logic                                              ram_busy
);

    localparam int BW = $clog2(BURST_COUNT);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_COUNT - 1);

    if (BURST_COUNT < 2 || (BURST_COUNT & (BURST_COUNT - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("line_burst_ctrl: unsupported parameter set");
    end

    logic [2:0]               state;
    logic [BW-1:0]            beat;
    logic                     accept;
    logic                     buf_wr;
    logic [DATA_BITWIDTH-1:0] buf_rd;
    logic [LINE_BITWIDTH-1:0] buf_line_nxt;

`ifdef LINE_BURST_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo;
`else
    assign resp_err = 1'b0;
`endif

    assign accept        = (state == IDLE) && req_valid && req_ready;
    assign buf_wr        = (state == RD_COLLECT) && ram_rd_data_valid;
    assign ram_data_mask = '0;

    // Read lines start from zero so a timed-out read returns 0 in missing slots.
    line_beat_buffer #(
        .BURST_COUNT  (BURST_COUNT),
        .DATA_BITWIDTH(DATA_BITWIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load_en  (accept),
        .load_line(req_write ? req_wdata : '0),
        .wr_en    (buf_wr),
        .wr_idx   (beat),
        .wr_data  (ram_rd_data),
        .rd_idx   (beat),
        .rd_data  (buf_rd),
        .line_nxt (buf_line_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            ram_cmd     <= 1'b0;
            ram_cmd_en  <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
`ifdef LINE_BURST_CTRL_TIMEOUT_EN
            resp_err    <= 1'b0;
            tmo         <= '0;
`endif
        end else begin
            ram_cmd_en <= 1'b0;
            resp_valid <= 1'b0;
            req_ready  <= 1'b0;
`ifdef LINE_BURST_CTRL_TIMEOUT_EN
            tmo        <= '0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        ram_cmd_en <= 1'b1;
                        ram_cmd    <= req_write ? CMD_WRITE : CMD_READ;
                        ram_addr   <= {req_addr, {BW{1'b0}}};
`ifdef LINE_BURST_CTRL_TIMEOUT_EN
                        resp_err   <= 1'b0;
`endif
                        if (req_write) begin
                            ram_wr_data <= req_wdata[DATA_BITWIDTH-1:0];
                            beat        <= BW'(1);
                            state       <= WR_ISSUE;
                        end else begin
                            beat  <= '0;
                            state <= RD_ISSUE;
                        end
                    end else begin
                        req_ready <= !ram_busy;
                    end
                end
                WR_ISSUE: begin
                    ram_wr_data <= buf_rd;
                    beat        <= beat + 1'b1;
                    state       <= WR_BEATS;
                end
                // beat wraps to 0 once the last slot has been driven
                WR_BEATS: begin
                    if (beat == '0) begin
                        state <= WAIT_IDLE;
                    end else begin
                        ram_wr_data <= buf_rd;
                        beat        <= beat + 1'b1;
                    end
                end
                RD_ISSUE: state <= RD_COLLECT;
                RD_COLLECT: begin
                    if (ram_rd_data_valid) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            resp_rdata <= buf_line_nxt;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
`ifdef LINE_BURST_CTRL_TIMEOUT_EN
                    else if (tmo == TMO_LAST) begin
                        resp_rdata <= buf_line_nxt;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        beat       <= '0;
                        state      <= RESP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
`endif
                end
                WAIT_IDLE: begin
                    if (!ram_busy) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= !ram_busy;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
